// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, selects next PC (jr/jump/branch/sequential),
// and runs a RUN/HALT/TRAP control FSM with a retired-fetch counter.
module pc_sequencer #(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             halt,
    input  logic             resume,
    input  logic             branch,
    input  logic [15:0]      imm,
    input  logic             jump,
    input  logic [25:0]      target,
    input  logic             jr,
    input  logic [WIDTH-1:0] rs_value,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic             running,
    output logic             misaligned,
    output logic [WIDTH-1:0] icount
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] icount_next;
    logic [WIDTH-1:0] redirect;
    logic [WIDTH-1:0] jump_pc;
    logic [WIDTH-1:0] branch_off;

    assign pc4 = pc + WIDTH'(4);

    // Jump keeps the top bits of pc4 and replaces the low 28 with the word target.
    always_comb begin
        jump_pc       = pc4;
        jump_pc[27:0] = {target, 2'b00};
    end

    assign branch_off = {{(WIDTH - 18){imm[15]}}, imm, 2'b00};

    // Next-PC candidate; priority jr > jump > branch > sequential.
    always_comb begin
        redirect = pc4;
        if (jr) begin
            redirect = rs_value;
        end else if (jump) begin
            redirect = jump_pc;
        end else if (branch) begin
            redirect = pc4 + branch_off;
        end
    end

    // Control FSM next-state and datapath updates.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        icount_next = icount;
        case (state)
            S_RUN: begin
                if (halt) begin
                    state_next = S_HALT;
                end else if (jr && (rs_value[1:0] != 2'b00)) begin
                    state_next = S_TRAP;
                end else begin
                    pc_next     = redirect;
                    icount_next = icount + WIDTH'(1);
                end
            end
            S_HALT: begin
                if (resume) begin
                    state_next = S_RUN;
                end
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // Status flags are registered alongside the state so they carry no input path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RUN;
            pc         <= RESET_PC;
            icount     <= '0;
            running    <= 1'b1;
            misaligned <= 1'b0;
        end else if (enable) begin
            state      <= state_next;
            pc         <= pc_next;
            icount     <= icount_next;
            running    <= (state_next == S_RUN);
            misaligned <= (state_next == S_TRAP);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed vectors push expected state per edge,
// a monitor pops and compares after each rising edge.
module tb_pc_sequencer;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] icount;
        logic        running;
        logic        misaligned;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             halt;
    logic             resume;
    logic             branch;
    logic [15:0]      imm;
    logic             jump;
    logic [25:0]      target;
    logic             jr;
    logic [WIDTH-1:0] rs_value;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc4;
    logic             running;
    logic             misaligned;
    logic [WIDTH-1:0] icount;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    pc_sequencer #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0080)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .halt       (halt),
        .resume     (resume),
        .branch     (branch),
        .imm        (imm),
        .jump       (jump),
        .target     (target),
        .jr         (jr),
        .rs_value   (rs_value),
        .pc         (pc),
        .pc4        (pc4),
        .running    (running),
        .misaligned (misaligned),
        .icount     (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        cmp({e.name, ".pc"}, pc, e.pc);
        cmp({e.name, ".pc4"}, pc4, e.pc + 32'd4);
        cmp({e.name, ".icount"}, icount, e.icount);
        cmp({e.name, ".running"}, 32'(running), 32'(e.running));
        cmp({e.name, ".misaligned"}, 32'(misaligned), 32'(e.misaligned));
    endtask

    // One edge of stimulus: drive on the falling edge and queue the state expected after the next rise.
    task automatic step(input string name, input logic en, input logic h, input logic rsm,
                        input logic br, input logic [15:0] im, input logic jp,
                        input logic [25:0] tg, input logic j, input logic [31:0] rs,
                        input logic [31:0] e_pc, input logic [31:0] e_ic,
                        input logic e_run, input logic e_mis);
        exp_t e;
        @(negedge clk);
        reset    = 1'b0;
        enable   = en;
        halt     = h;
        resume   = rsm;
        branch   = br;
        imm      = im;
        jump     = jp;
        target   = tg;
        jr       = j;
        rs_value = rs;
        e.name = name;
        e.pc = e_pc;
        e.icount = e_ic;
        e.running = e_run;
        e.misaligned = e_mis;
        sb_q.push_back(e);
    endtask

    task automatic clear_inputs();
        enable   = 1'b1;
        halt     = 1'b0;
        resume   = 1'b0;
        branch   = 1'b0;
        imm      = '0;
        jump     = 1'b0;
        target   = '0;
        jr       = 1'b0;
        rs_value = '0;
    endtask

    // Monitor: compares registered state shortly after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_all(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t r;
        reset = 1'b1;
        clear_inputs();
        #3;
        r.name = "reset"; r.pc = 32'h80; r.icount = 0; r.running = 1'b1; r.misaligned = 1'b0;
        check_all(r);

        // Sequential fetch
        step("seq0", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h84, 1, 1, 0);
        step("seq1", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h88, 2, 1, 0);
        step("seq2", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h8C, 3, 1, 0);

        // Branches backward and forward
        step("br_neg", 1, 0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 32'h88, 4, 1, 0);
        step("br_pos", 1, 0, 0, 1, 16'h0005, 0, 26'h0, 0, 32'h0, 32'hA0, 5, 1, 0);

        // Jump beats branch
        step("jump", 1, 0, 0, 1, 16'h0005, 1, 26'h40, 0, 32'h0, 32'h100, 6, 1, 0);

        // Halt beats jr; halted requests ignored; resume holds pc
        step("halt", 1, 1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h200, 32'h100, 6, 0, 0);
        step("hold0", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h100, 6, 0, 0);
        step("hold1", 1, 1, 0, 1, 16'h0010, 0, 26'h0, 0, 32'h0, 32'h100, 6, 0, 0);
        step("hold2", 1, 0, 0, 0, 16'h0, 1, 26'h123, 0, 32'h0, 32'h100, 6, 0, 0);
        step("hold3", 1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h300, 32'h100, 6, 0, 0);
        step("resume", 1, 0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h100, 6, 1, 0);
        step("post_res", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h104, 7, 1, 0);

        // Misaligned jr traps; everything ignored afterwards
        step("trap", 1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h102, 32'h104, 7, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("trap_hold%0d", i), 1, 0, 1, 0, 16'h0, 1, 26'h40, 0, 32'h0,
                 32'h104, 7, 0, 1);
        end

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        reset = 1'b1;
        clear_inputs();
        #1;
        r.name = "async_rst"; r.pc = 32'h80; r.icount = 0; r.running = 1'b1; r.misaligned = 1'b0;
        check_all(r);

        // Aligned jr beats jump
        step("jr_ok", 1, 0, 0, 0, 16'h0, 1, 26'h40, 1, 32'h400, 32'h400, 1, 1, 0);

        // enable=0 freezes everything
        for (int i = 0; i < 4; i++) begin
            step($sformatf("frozen%0d", i), 0, 0, 0, 1, 16'h0005, 1, 26'h3, 0, 32'h0,
                 32'h400, 1, 1, 0);
        end

        // Wrap from top of address space
        step("to_top", 1, 0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, 1, 0);
        step("wrap", 1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0, 3, 1, 0);

        @(posedge clk);
        #3;
        cmp("drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
